// File: rtl/vga_scan_ctrl.sv
// VGA raster scanner: hc/vc counters drive an external coordinate mapper, stage 1
// issues the image RAM read and stage 2 picks the pixel colour, keeping syncs aligned.
module vga_scan_ctrl #(
   parameter int unsigned H_ACTIVE = 800,
   parameter int unsigned H_FP     = 40,
   parameter int unsigned H_SYNC   = 128,
   parameter int unsigned H_BP     = 88,
   parameter int unsigned V_ACTIVE = 600,
   parameter int unsigned V_FP     = 1,
   parameter int unsigned V_SYNC   = 4,
   parameter int unsigned V_BP     = 23,
   parameter int unsigned IMG_X0   = 231,
   parameter int unsigned IMG_X1   = 711,
   parameter int unsigned IMG_Y0   = 36,
   parameter int unsigned IMG_Y1   = 516,
   parameter logic [11:0] BG_COLOR = 12'h000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic        en,
   output logic [21:0] display_addr,
   input  logic [3:0]  pixel_x,
   input  logic [3:0]  pixel_y,
   output logic [7:0]  mem_addr,
   output logic        mem_rd,
   input  logic [11:0] mem_data,
   output logic [11:0] rgb,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 32'd1);
   localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 32'd1);
   localparam logic [10:0] H_ACT_C = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT_C = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] X0_C    = 11'(IMG_X0);
   localparam logic [10:0] X1_C    = 11'(IMG_X1);
   localparam logic [10:0] Y0_C    = 11'(IMG_Y0);
   localparam logic [10:0] Y1_C    = 11'(IMG_Y1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t      state_q;
   logic [10:0] hc_q;
   logic [10:0] vc_q;
   logic        s1_vld_q;
   logic        s1_img_q;
   logic        s1_act_q;
   logic        s1_hs_q;
   logic        s1_vs_q;
   logic [7:0]  mem_addr_q;
   logic        mem_rd_q;
   logic [11:0] rgb_q;
   logic        hsync_q;
   logic        vsync_q;
   logic        frame_start_q;

   logic        adv_d;
   logic        frame_end_d;
   logic        to_idle_d;
   logic        in_img_d;
   logic        active_d;
   logic        hs_d;
   logic        vs_d;
   logic [10:0] hc_d;
   logic [10:0] vc_d;
   logic [11:0] rgb_d;

   function automatic logic in_span(input logic [10:0] v,
                                    input logic [10:0] lo,
                                    input logic [10:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

   // Advance decode, window/sync classification of the current position and stage-2 colour select
   always_comb begin
      adv_d       = pix_en && (state_q != ST_IDLE);
      frame_end_d = (hc_q == H_LAST) && (vc_q == V_LAST);
      to_idle_d   = adv_d && frame_end_d && (state_q == ST_DRAIN) && !en;
      in_img_d    = in_span(hc_q, X0_C, X1_C) && in_span(vc_q, Y0_C, Y1_C);
      active_d    = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
      hs_d        = in_span(hc_q, HS_BEG, HS_END);
      vs_d        = in_span(vc_q, VS_BEG, VS_END);
      if (hc_q == H_LAST) begin
         hc_d = 11'd0;
         if (vc_q == V_LAST) begin
            vc_d = 11'd0;
         end else begin
            vc_d = vc_q + 11'd1;
         end
      end else begin
         hc_d = hc_q + 11'd1;
         vc_d = vc_q;
      end
      // An empty stage 1 (first advance after start) shows background, not black
      if (!s1_vld_q) begin
         rgb_d = BG_COLOR;
      end else if (!s1_act_q) begin
         rgb_d = 12'h000;
      end else if (s1_img_q) begin
         rgb_d = mem_data;
      end else begin
         rgb_d = BG_COLOR;
      end
   end

   // Scan FSM, counters and both pipeline stages
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         hc_q          <= 11'd0;
         vc_q          <= 11'd0;
         s1_vld_q      <= 1'b0;
         s1_img_q      <= 1'b0;
         s1_act_q      <= 1'b0;
         s1_hs_q       <= 1'b0;
         s1_vs_q       <= 1'b0;
         mem_addr_q    <= 8'd0;
         mem_rd_q      <= 1'b0;
         rgb_q         <= BG_COLOR;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= 1'b0;
         mem_rd_q      <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               hc_q     <= 11'd0;
               vc_q     <= 11'd0;
               s1_vld_q <= 1'b0;
               s1_img_q <= 1'b0;
               s1_act_q <= 1'b0;
               s1_hs_q  <= 1'b0;
               s1_vs_q  <= 1'b0;
               rgb_q    <= BG_COLOR;
               hsync_q  <= 1'b0;
               vsync_q  <= 1'b0;
               if (pix_en && en) begin
                  state_q       <= ST_RUN;
                  frame_start_q <= 1'b1;
               end
            end
            ST_RUN, ST_DRAIN: begin
               if (to_idle_d) begin
                  state_q    <= ST_IDLE;
                  hc_q       <= 11'd0;
                  vc_q       <= 11'd0;
                  mem_addr_q <= {pixel_y, pixel_x};
                  s1_vld_q   <= 1'b0;
                  s1_img_q   <= 1'b0;
                  s1_act_q   <= 1'b0;
                  s1_hs_q    <= 1'b0;
                  s1_vs_q    <= 1'b0;
                  rgb_q      <= BG_COLOR;
                  hsync_q    <= 1'b0;
                  vsync_q    <= 1'b0;
               end else begin
                  state_q <= en ? ST_RUN : ST_DRAIN;
                  if (adv_d) begin
                     hc_q          <= hc_d;
                     vc_q          <= vc_d;
                     mem_addr_q    <= {pixel_y, pixel_x};
                     mem_rd_q      <= in_img_d && active_d;
                     s1_vld_q      <= 1'b1;
                     s1_img_q      <= in_img_d;
                     s1_act_q      <= active_d;
                     s1_hs_q       <= hs_d;
                     s1_vs_q       <= vs_d;
                     rgb_q         <= rgb_d;
                     hsync_q       <= s1_hs_q;
                     vsync_q       <= s1_vs_q;
                     frame_start_q <= frame_end_d;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign display_addr = {hc_q, vc_q};
   assign mem_addr     = mem_addr_q;
   assign mem_rd       = mem_rd_q;
   assign rgb          = rgb_q;
   assign hsync        = hsync_q;
   assign vsync        = vsync_q;
   assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl on a shrunken raster with a mapper and RAM model.
module tb_vga_scan_ctrl;

   localparam int HA = 20, HFP = 2, HS = 3, HBP = 3;
   localparam int VA = 10, VFP = 1, VS = 2, VBP = 2;
   localparam int X0 = 5, X1 = 15, Y0 = 3, Y1 = 8;
   localparam logic [11:0] BG = 12'hA5C;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int ST_I = 0, ST_R = 1, ST_D = 2;
   localparam logic [13:0] BUBBLE = {BG, 2'b00};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pix_en = 1'b0;
   logic        en = 1'b0;
   logic [21:0] display_addr;
   logic [3:0]  pixel_x, pixel_y;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [11:0] mem_data;
   logic [11:0] rgb;
   logic        hsync, vsync, frame_start;

   vga_scan_ctrl #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .IMG_X0(X0), .IMG_X1(X1), .IMG_Y0(Y0), .IMG_Y1(Y1),
      .BG_COLOR(BG)
   ) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .en(en),
      .display_addr(display_addr), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
      .rgb(rgb), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] ram_word(input logic [7:0] a);
      return 12'h100 + {4'h0, a};
   endfunction

   // Mapper: offset from the window origin, truncated to 4 bits
   logic [10:0] dx, dy;
   assign dx = display_addr[21:11] - 11'(X0);
   assign dy = display_addr[10:0] - 11'(Y0);
   assign pixel_x = dx[3:0];
   assign pixel_y = dy[3:0];

   // RAM: data appears while mem_rd is high and is held until the next read
   logic [11:0] ram_hold = 12'h000;
   assign mem_data = mem_rd ? ram_word(mem_addr) : ram_hold;
   always @(posedge clk) if (mem_rd) ram_hold <= ram_word(mem_addr);

   int n_chk = 0, n_err = 0;
   int cyc = 0, fs_last = 0, fs_prev = 0;
   int m_st, m_hc, m_vc;
   logic [7:0]  m_addr;
   logic [13:0] m_out;
   logic [13:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d, model hc=%0d vc=%0d)",
                  tag, act, exp, cyc, m_hc, m_vc);
      end
   endtask

   function automatic logic is_act(input int h, input int v);
      return (h < HA) && (v < VA);
   endfunction

   function automatic logic is_img(input int h, input int v);
      return (h >= X0) && (h < X1) && (v >= Y0) && (v < Y1);
   endfunction

   function automatic logic [7:0] map_addr(input int h, input int v);
      return {4'(v - Y0), 4'(h - X0)};
   endfunction

   function automatic logic [13:0] px_tuple(input int h, input int v);
      logic [11:0] c;
      logic hs_e, vs_e;
      hs_e = (h >= HA + HFP) && (h < HA + HFP + HS);
      vs_e = (v >= VA + VFP) && (v < VA + VFP + VS);
      if (!is_act(h, v)) c = 12'h000;
      else if (is_img(h, v)) c = ram_word(map_addr(h, v));
      else c = BG;
      return {c, hs_e, vs_e};
   endfunction

   task automatic model_idle();
      m_st = ST_I; m_hc = 0; m_vc = 0; m_out = BUBBLE;
      exp_q.delete();
   endtask

   task automatic model_reset();
      model_idle();
      m_addr = 8'd0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_disp"}, 32'(display_addr), 32'd0);
      check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
      check_eq({tag, "_rd"},   32'(mem_rd), 32'd0);
      check_eq({tag, "_pix"},  32'({rgb, hsync, vsync}), 32'(BUBBLE));
      check_eq({tag, "_fs"},   32'(frame_start), 32'd0);
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge
   task automatic step(input logic p, input logic e);
      logic adv, fend, exp_fs, exp_rd;
      pix_en = p; en = e;
      adv = p && (m_st != ST_I);
      fend = (m_hc == HT - 1) && (m_vc == VT - 1);
      exp_fs = 1'b0; exp_rd = 1'b0;
      if (m_st == ST_I) begin
         if (p && e) begin
            m_st = ST_R; exp_fs = 1'b1;
            exp_q.delete(); exp_q.push_back(BUBBLE);
         end
      end else if (adv && fend && m_st == ST_D && !e) begin
         m_addr = map_addr(m_hc, m_vc);
         model_idle();
      end else begin
         if (adv) begin
            exp_rd = is_act(m_hc, m_vc) && is_img(m_hc, m_vc);
            m_addr = map_addr(m_hc, m_vc);
            exp_q.push_back(px_tuple(m_hc, m_vc));
            m_out = exp_q.pop_front();
            exp_fs = fend;
            if (m_hc == HT - 1) begin
               m_hc = 0;
               m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
            end else begin
               m_hc = m_hc + 1;
            end
         end
         m_st = e ? ST_R : ST_D;
      end
      @(posedge clk); #1; cyc++;
      check_eq("disp", 32'(display_addr), 32'({11'(m_hc), 11'(m_vc)}));
      check_eq("mem_rd", 32'(mem_rd), 32'(exp_rd));
      check_eq("mem_addr", 32'(mem_addr), 32'(m_addr));
      check_eq("pix", 32'({rgb, hsync, vsync}), 32'(m_out));
      check_eq("frame_start", 32'(frame_start), 32'(exp_fs));
      if (frame_start) begin fs_prev = fs_last; fs_last = cyc; end
   endtask

   task automatic run_to(input int h, input int v, input logic e);
      int i;
      for (i = 0; i < 2 * HT * VT && !(m_hc == h && m_vc == v); i++) step(1'b1, e);
      check_eq("run_to_bound", 32'(m_hc == h && m_vc == v), 32'd1);
   endtask

   initial begin
      model_reset();
      #1 rst = 1'b1;
      #2 check_reset_outputs("por");
      @(posedge clk); #1 rst = 1'b0;

      // Start and one full frame at full rate
      step(1'b1, 1'b1);
      repeat (HT * VT + 30) step(1'b1, 1'b1);
      check_eq("fs_period", 32'(fs_last - fs_prev), 32'(HT * VT));

      // Stall: 1-0-1 and occasional longer gaps across image lines
      run_to(X0 - 3, Y0 + 1, 1'b1);
      for (int k = 0; k < 80; k++) begin
         step(1'b1, 1'b1);
         step(1'b0, 1'b1);
         if ($urandom_range(0, 1) == 1) step(1'b0, 1'b1);
      end

      // Drain to IDLE, then stay idle regardless of pix_en
      run_to(0, 6, 1'b1);
      for (int k = 0; k < 2 * HT * VT && m_st != ST_I; k++) step(1'b1, 1'b0);
      check_eq("drain_bound", 32'(m_st), 32'(ST_I));
      repeat (5) step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);

      // Restart, drop en, re-raise inside DRAIN: frames continue
      step(1'b1, 1'b1);
      run_to(0, 5, 1'b1);
      for (int k = 0; k < 2 * HT * VT && m_vc != 11; k++) step(1'b1, 1'b0);
      run_to(3, 0, 1'b1);

      // en returns exactly on the frame-end advance while draining
      run_to(0, 12, 1'b1);
      run_to(HT - 1, VT - 1, 1'b0);
      step(1'b1, 1'b1);
      repeat (10) step(1'b1, 1'b1);

      // Asynchronous reset mid-line inside the image window
      run_to(14, 4, 1'b1);
      #2 rst = 1'b1;
      #1 check_reset_outputs("async");
      model_reset();
      @(posedge clk); #1 rst = 1'b0;
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      repeat (40) step(1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- H_ACTIVE 800: visible columns.
- H_FP 40: horizontal front porch.
- H_SYNC 128: horizontal sync width.
- H_BP 88: horizontal back porch.
- V_ACTIVE 600: visible lines.
- V_FP 1: vertical front porch.
- V_SYNC 4: vertical sync width.
- V_BP 23: vertical back porch.
- IMG_X0 231, IMG_X1 711, IMG_Y0 36, IMG_Y1 516: image window, half-open.
- BG_COLOR 12'h000: colour outside the image window.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk in 1: single clock.
- rst in 1: asynchronous, active-high reset.
- pix_en in 1: pixel-advance strobe.
- en in 1: scan enable.
- display_addr out 22: {x[10:0], y[10:0]} fed to the coordinate mapper.
- pixel_x in 4, pixel_y in 4: mapper result, combinational from display_addr.
- mem_addr out 8: {pixel_y, pixel_x}.
- mem_rd out 1: image RAM read strobe.
- mem_data in 12: RAM data, valid the clk after mem_rd and held until the next mem_rd.
- rgb out 12: pixel colour.
- hsync out 1, vsync out 1: sync outputs, active-high.
- frame_start out 1: one-clk frame pulse.

Function
REQ-003 SHALL keep counters hc (0..H_ACTIVE+H_FP+H_SYNC+H_BP-1 = 1055) and vc (0..627).
- Counters advance only on clk edges where pix_en=1 and state is RUN or DRAIN.
REQ-004 SHALL wrap hc from 1055 to 0 and increment vc on that same edge; vc SHALL wrap from 627 to 0 when hc wraps.
REQ-005 SHALL drive display_addr = {hc, vc} combinationally from the counters (stage 0).
REQ-006 SHALL implement FSM IDLE/RUN/DRAIN:
- IDLE->RUN on pix_en & en, with hc=vc=0.
- RUN->DRAIN when en=0.
- DRAIN->RUN when en=1.
- DRAIN->IDLE on the advance from (1055,627).
- Simultaneous en=1 at frame end in DRAIN: stay RUN.
REQ-007 SHALL, in IDLE, hold the counters at 0 and drive mem_rd=0, rgb=BG_COLOR, hsync=0, vsync=0.
REQ-008 Stage 1, on each advance, SHALL register:
- mem_addr={pixel_y,pixel_x}.
- in_img = (IMG_X0<=hc<IMG_X1) & (IMG_Y0<=vc<IMG_Y1).
- active = (hc<H_ACTIVE) & (vc<V_ACTIVE).
- hs = (H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC).
- vs likewise on vc.
REQ-009 SHALL pulse mem_rd high for exactly one clk on each advance where in_img & active is being registered; otherwise mem_rd=0.
REQ-010 Stage 2, on each advance, SHALL register:
- rgb = mem_data if stage-1 in_img & active; BG_COLOR if active & !in_img; 12'h000 if !active.
- hsync and vsync from the stage-1 values.
REQ-011 Total latency SHALL be exactly 2 advances from counter value to the rgb/hsync/vsync outputs; syncs SHALL stay aligned to rgb.
REQ-012 SHALL pulse frame_start for one clk on the advance where the counters leave (1055,627), and on the IDLE->RUN transition.
REQ-013 SHALL keep stages 1-2 flushing normally in DRAIN; entering IDLE SHALL force the outputs of REQ-007 on the next clk.
REQ-014 SHALL hold all registers and outputs unchanged when pix_en=0, except that mem_rd SHALL return to 0 after its one-clk pulse.
REQ-015 SHALL assume pix_en is never high on two consecutive clks unless the RAM has 1-clk latency; mem_data SHALL be sampled only on advances.

Reset
REQ-016 rst=1 SHALL immediately, asynchronously, set:
- state=IDLE, hc=vc=0.
- mem_addr=0, mem_rd=0.
- rgb=BG_COLOR, hsync=0, vsync=0, frame_start=0.
- pipeline valid/in_img/active=0.
REQ-017 rst asserted mid-frame SHALL abandon the frame.
- After release, scanning SHALL restart from (0,0) only via IDLE->RUN.

Verification
REQ-018 Reset-and-start: rst pulse, then en=1 and pix_en every clk -> frame_start high 1 clk; display_addr={11'd0,11'd0}; rgb=BG_COLOR(0) for the first 2 advances.
REQ-019 Timing: full frame with pix_en=1 -> hsync high for hc 840..967 (delayed 2 clks); vsync high for vc 601..604; 1056x628=663168 clks between frame_start pulses.
REQ-020 Image fetch: RAM model mem[a]=a, scan line vc=36 -> mem_rd asserted for hc 231..710; mem_addr 8'h00 at hc 231..260 and 8'h01 at hc 261..290; rgb=12'h000 at hc 233, then 12'h001 at hc 263 (2-clk delay); hc 230 -> BG_COLOR, no mem_rd.
REQ-021 Stall: pix_en toggling 1-0-1 -> hc increments only on pix_en=1 clks; mem_rd is a 1-clk pulse; rgb unchanged during pix_en=0.
REQ-022 Drain: en dropped at vc=300 -> frame completes; at the (1055,627) advance, state goes IDLE, no frame_start pulse, outputs as REQ-007. en re-raised at vc=500 in DRAIN -> continuous frames, frame_start at the wrap.
REQ-023 Async reset mid-line (hc=500, vc=200) -> outputs reach reset values in the same clk without a clk edge; the next run starts at (0,0).
